// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the iterative divider: operand width, iteration
// counter width, RV32M divide op encodings, sequencer states and op-decode
// helpers.
package div_ctrl_pkg;

  localparam int unsigned CPU_WIDTH     = 32;
  localparam int unsigned DIV_CNT_WIDTH = 6;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  // op[0] clear selects the signed variants (DIV, REM)
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // op[1] set selects the remainder variants (REM, REMU)
  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_ctrl_step.sv
// One combinational radix-2 restoring division iteration.
//   rem_i / rem_o : partial remainder, WIDTH+1 bits
//   quo_i / quo_o : shifting dividend / quotient register, WIDTH bits
//   divisor_i     : divisor magnitude, WIDTH bits
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    // One guard bit above the trial width: the MSB of diff is the borrow.
    diff    = shifted - {2'b00, divisor_i};
    borrow  = diff[WIDTH+1];
    rem_o   = borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
    quo_o   = {quo_i[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divider with sequencer for RV32M
// DIV/DIVU/REM/REMU, including sign fix-up and the divide-by-zero and
// signed-overflow special cases.
//   clk, rst_n        : clock, asynchronous active-low reset
//   div_start_i       : request, sampled only in IDLE
//   div_op_i          : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i        : rs1 value, divisor_i : rs2 value
//   flush_i           : aborts any operation, no ready pulse
//   div_res_ready_o   : one-cycle result-valid pulse
//   div_result_o      : registered result, held until the next result
//   div_busy_o        : high in CALC and DONE
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = CPU_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_start_i,
  input  logic [1:0]       div_op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             flush_i,
  output logic             div_res_ready_o,
  output logic [WIDTH-1:0] div_result_o,
  output logic             div_busy_o
);

  div_state_e       state_q;
  logic             op_rem_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             ready_q;
  logic             busy_q;

  logic             a_neg, b_neg, is_ovf;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] final_d;

  always_comb begin
    a_neg   = op_is_signed(div_op_i) & dividend_i[WIDTH-1];
    b_neg   = op_is_signed(div_op_i) & divisor_i[WIDTH-1];
    a_mag   = a_neg ? (~dividend_i + 1'b1) : dividend_i;
    b_mag   = b_neg ? (~divisor_i + 1'b1) : divisor_i;
    is_ovf  = op_is_signed(div_op_i)
              && (dividend_i == {1'b1, {(WIDTH-1){1'b0}}})
              && (divisor_i == '1);
    // Value loaded into the result register on the final iteration.
    final_d = '0;
    if (op_rem_q) final_d = neg_rem_q ? (~rem_d[WIDTH-1:0] + 1'b1) : rem_d[WIDTH-1:0];
    else          final_d = neg_quo_q ? (~quo_d + 1'b1) : quo_d;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (rem_d),
    .quo_o     (quo_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvsr_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (flush_i) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (div_start_i) begin
              op_rem_q  <= op_is_rem(div_op_i);
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              dvsr_q    <= b_mag;
              rem_q     <= '0;
              quo_q     <= a_mag;
              cnt_q     <= '0;
              busy_q    <= 1'b1;
              // Special cases bypass iteration and present their result directly.
              if (divisor_i == '0) begin
                result_q <= op_is_rem(div_op_i) ? dividend_i : '1;
                ready_q  <= 1'b1;
                state_q  <= ST_DONE;
              end else if (is_ovf) begin
                result_q <= op_is_rem(div_op_i) ? '0 : dividend_i;
                ready_q  <= 1'b1;
                state_q  <= ST_DONE;
              end else begin
                state_q  <= ST_CALC;
              end
            end
          end
          ST_CALC: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) begin
              result_q <= final_d;
              ready_q  <= 1'b1;
              state_q  <= ST_DONE;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign div_res_ready_o = ready_q;
  assign div_result_o    = result_q;
  assign div_busy_o      = busy_q;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        div_start_i = 1'b0;
  logic [1:0]  div_op_i = 2'b00;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic        flush_i = 1'b0;
  logic        div_res_ready_o;
  logic [31:0] div_result_o;
  logic        div_busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .div_start_i     (div_start_i),
    .div_op_i        (div_op_i),
    .dividend_i      (dividend_i),
    .divisor_i       (divisor_i),
    .flush_i         (flush_i),
    .div_res_ready_o (div_res_ready_o),
    .div_result_o    (div_result_o),
    .div_busy_o      (div_busy_o)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. Latency counts negedges after the
  // accepting posedge, so a normal divide reports 33 and a special case 1.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic pulse_ok);
    div_op_i    = op;
    dividend_i  = a;
    divisor_i   = b;
    div_start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_start_i = 1'b0;
    dividend_i  = $urandom;
    divisor_i   = $urandom;
    div_op_i    = 2'($urandom_range(0, 3));
    lat = 1;
    while (!div_res_ready_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = div_result_o;
    @(negedge clk);
    pulse_ok = !div_res_ready_o && !div_busy_o;
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] prev;
    int          lat;
    logic        pulse_ok;
    logic        saw_ready;

    vecs.push_back(vec_t'{"divu_100_7",   2'b01, 32'd100,      32'd7,        32'd14,       33});
    vecs.push_back(vec_t'{"remu_100_7",   2'b11, 32'd100,      32'd7,        32'd2,        33});
    vecs.push_back(vec_t'{"div_m7_2",     2'b00, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
    vecs.push_back(vec_t'{"rem_m7_2",     2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
    vecs.push_back(vec_t'{"rem_7_m2",     2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        33});
    vecs.push_back(vec_t'{"div_m100_m7",  2'b00, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       33});
    vecs.push_back(vec_t'{"rem_m100_m7",  2'b10, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 33});
    vecs.push_back(vec_t'{"div_100_m7",   2'b00, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33});
    vecs.push_back(vec_t'{"divu_min_m1",  2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33});
    vecs.push_back(vec_t'{"remu_min_m1",  2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33});
    vecs.push_back(vec_t'{"div_by0",      2'b00, 32'h12345678, 32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back(vec_t'{"divu_by0",     2'b01, 32'h12345678, 32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back(vec_t'{"rem_by0",      2'b10, 32'h12345678, 32'd0,        32'h12345678, 1});
    vecs.push_back(vec_t'{"remu_by0",     2'b11, 32'h12345678, 32'd0,        32'h12345678, 1});
    vecs.push_back(vec_t'{"div_ovf",      2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back(vec_t'{"rem_ovf",      2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1});

    // Reset state
    #12;
    check("rst_ready",  {31'd0, div_res_ready_o}, 32'd0);
    check("rst_busy",   {31'd0, div_busy_o},      32'd0);
    check("rst_result", div_result_o,             32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, pulse_ok);
      check({vecs[i].name, "_res"},   res,                vecs[i].exp);
      check({vecs[i].name, "_lat"},   32'(lat),           32'(vecs[i].lat));
      check({vecs[i].name, "_pulse"}, {31'd0, pulse_ok},  32'd1);
    end

    // Flush at CALC cycle 10: no ready, result unchanged, busy drops.
    prev = div_result_o;
    div_op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd3; div_start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_start_i = 1'b0;
    check("flush_busy_calc", {31'd0, div_busy_o}, 32'd1);
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_busy",   {31'd0, div_busy_o},      32'd0);
    check("flush_result", div_result_o,             prev);
    saw_ready = div_res_ready_o;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      saw_ready = saw_ready | div_res_ready_o;
    end
    check("flush_no_ready", {31'd0, saw_ready},   32'd0);
    check("flush_hold",     div_result_o,         prev);
    run_op(2'b01, 32'd1000, 32'd3, res, lat, pulse_ok);
    check("after_flush_res", res,       32'd333);
    check("after_flush_lat", 32'(lat),  32'd33);

    // Asynchronous reset mid-CALC.
    div_op_i = 2'b01; dividend_i = 32'hFFFFFFFF; divisor_i = 32'd1; div_start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_start_i = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready",  {31'd0, div_res_ready_o}, 32'd0);
    check("midrst_busy",   {31'd0, div_busy_o},      32'd0);
    check("midrst_result", div_result_o,             32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_idle_busy", {31'd0, div_busy_o}, 32'd0);
    run_op(2'b01, 32'hFFFFFFFF, 32'd1, res, lat, pulse_ok);
    check("after_rst_res", res,      32'hFFFFFFFF);
    check("after_rst_lat", 32'(lat), 32'd33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
